// File: rtl/wts_mixer_pkg.sv
// wts_mixer_pkg: shared FSM states, volume width and clog2 helper for the TDM mixer
package wts_mixer_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;
  localparam int VOL_W = 4;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/wts_mixer_sat.sv
// wts_mixer_sat: arithmetic shift of an accumulator then saturation to OUT_W with clip flag
module wts_mixer_sat #(
  parameter int ACC_W = 15,
  parameter int OUT_W = 12,
  parameter int SHIFT = 2
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [OUT_W-1:0] o_out,
  output logic                    o_clip
);
  localparam logic signed [ACC_W-1:0] MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MIN = ~MAX;
  logic signed [ACC_W-1:0] w_s;
  logic w_hi, w_lo;
  assign w_s = i_acc >>> SHIFT;
  assign w_hi = w_s > MAX;
  assign w_lo = w_s < MIN;
  assign o_clip = w_hi | w_lo;
  assign o_out = w_hi ? MAX[OUT_W-1:0] : w_lo ? MIN[OUT_W-1:0] : w_s[OUT_W-1:0];
endmodule

// File: rtl/wts_mixer_tdm.sv
// wts_mixer_tdm: time-multiplexed stereo mixer, one channel multiply-accumulate per cycle
module wts_mixer_tdm
  import wts_mixer_pkg::*;
#(
  parameter int N_CH     = 5,
  parameter int SAMPLE_W = 8,
  parameter int OUT_W    = 12,
  parameter int SHIFT    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic [N_CH*SAMPLE_W-1:0]     ch_sample,
  input  logic [N_CH*VOL_W-1:0]        ch_volume,
  input  logic [N_CH*2-1:0]            ch_enable,
  input  logic                         master_mute,
  output logic signed [OUT_W-1:0]      left_out,
  output logic signed [OUT_W-1:0]      right_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic [1:0]                   clip,
  output logic                         overrun
);
  localparam int ACC_W = SAMPLE_W + VOL_W + clog2(N_CH) + 1;
  localparam int IDX_W = N_CH > 1 ? clog2(N_CH) : 1;
  localparam int P_W   = SAMPLE_W + VOL_W + 1;
  state_t r_state, w_next;
  logic [N_CH*SAMPLE_W-1:0] r_sample;
  logic [N_CH*VOL_W-1:0] r_volume;
  logic [N_CH*2-1:0] r_enable;
  logic r_mute, r_valid, r_overrun;
  logic [IDX_W-1:0] r_idx;
  logic signed [ACC_W-1:0] r_acc_l, r_acc_r;
  logic signed [OUT_W-1:0] r_left, r_right, w_sat_l, w_sat_r;
  logic [1:0] r_clip;
  logic [SAMPLE_W-1:0] w_smp;
  logic [VOL_W-1:0] w_vol;
  logic [1:0] w_en;
  logic signed [P_W-1:0] w_p;
  logic signed [ACC_W-1:0] w_pe;
  logic w_last, w_clip_l, w_clip_r, w_start;
  assign w_smp = r_sample[int'(r_idx)*SAMPLE_W +: SAMPLE_W];
  assign w_vol = r_volume[int'(r_idx)*VOL_W +: VOL_W];
  assign w_en = r_enable[int'(r_idx)*2 +: 2];
  // volume is unsigned, so it gets a zero sign bit before the signed multiply
  assign w_p = P_W'(signed'(w_smp)) * P_W'(signed'({1'b0, w_vol}));
  assign w_pe = ACC_W'(w_p);
  assign w_last = r_idx == IDX_W'(N_CH - 1);
  assign w_start = r_state == IDLE && frame_start;
  always_comb begin
    w_next = r_state;
    w_next = w_start ? ACCUM : (r_state == ACCUM && w_last) ? FINISH : (r_state == FINISH) ? IDLE : r_state;
  end
  wts_mixer_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat_l (
    .i_acc(r_acc_l), .o_out(w_sat_l), .o_clip(w_clip_l)
  );
  wts_mixer_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat_r (
    .i_acc(r_acc_r), .o_out(w_sat_r), .o_clip(w_clip_r)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sample <= '0;
      r_volume <= '0;
      r_enable <= '0;
      r_mute <= 1'b0;
      r_idx <= '0;
      r_acc_l <= '0;
      r_acc_r <= '0;
      r_left <= '0;
      r_right <= '0;
      r_clip <= 2'b00;
      r_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= 1'b0;
      r_overrun <= frame_start && r_state != IDLE;
      if (w_start) begin
        r_sample <= ch_sample;
        r_volume <= ch_volume;
        r_enable <= ch_enable;
        r_mute <= master_mute;
        r_idx <= '0;
        r_acc_l <= '0;
        r_acc_r <= '0;
      end
      if (r_state == ACCUM) begin
        r_acc_l <= w_en[1] ? r_acc_l + w_pe : r_acc_l;
        r_acc_r <= w_en[0] ? r_acc_r + w_pe : r_acc_r;
        r_idx <= r_idx + IDX_W'(1);
      end
      if (r_state == FINISH) begin
        r_left <= r_mute ? '0 : w_sat_l;
        r_right <= r_mute ? '0 : w_sat_r;
        r_clip <= r_mute ? 2'b00 : {w_clip_l, w_clip_r};
        r_valid <= 1'b1;
      end
    end
  end
  assign left_out = r_left;
  assign right_out = r_right;
  assign out_valid = r_valid;
  assign clip = r_clip;
  assign overrun = r_overrun;
  assign busy = r_state != IDLE || r_valid;
endmodule

// File: tb/tb_wts_mixer_tdm.sv
// tb_wts_mixer_tdm: directed vector table plus reset/overrun/mute corner sequences
module tb_wts_mixer_tdm;
  logic clk = 1'b0, reset = 1'b1, frame_start = 1'b0, master_mute = 1'b0;
  logic [31:0] ch_sample = '0;
  logic [15:0] ch_volume = '0;
  logic [7:0] ch_enable = '0;
  logic signed [11:0] a_l, a_r, b_l, b_r, c_l, c_r;
  logic a_v, b_v, c_v, a_b, b_b, c_b, a_o, b_o, c_o;
  logic [1:0] a_c, b_c, c_c;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  wts_mixer_tdm #(.N_CH(4), .SAMPLE_W(8), .OUT_W(12), .SHIFT(2)) dut_a (
    .clk(clk), .reset(reset), .frame_start(frame_start), .ch_sample(ch_sample),
    .ch_volume(ch_volume), .ch_enable(ch_enable), .master_mute(master_mute),
    .left_out(a_l), .right_out(a_r), .out_valid(a_v), .busy(a_b), .clip(a_c), .overrun(a_o)
  );
  wts_mixer_tdm #(.N_CH(4), .SAMPLE_W(8), .OUT_W(12), .SHIFT(0)) dut_b (
    .clk(clk), .reset(reset), .frame_start(frame_start), .ch_sample(ch_sample),
    .ch_volume(ch_volume), .ch_enable(ch_enable), .master_mute(master_mute),
    .left_out(b_l), .right_out(b_r), .out_valid(b_v), .busy(b_b), .clip(b_c), .overrun(b_o)
  );
  wts_mixer_tdm #(.N_CH(1), .SAMPLE_W(8), .OUT_W(12), .SHIFT(2)) dut_c (
    .clk(clk), .reset(reset), .frame_start(frame_start), .ch_sample(ch_sample[7:0]),
    .ch_volume(ch_volume[3:0]), .ch_enable(ch_enable[1:0]), .master_mute(master_mute),
    .left_out(c_l), .right_out(c_r), .out_valid(c_v), .busy(c_b), .clip(c_c), .overrun(c_o)
  );
  typedef struct {
    logic [31:0] s;
    logic [15:0] v;
    logic [7:0] e;
    logic m;
    int al, ar, ac;
    int bl, br, bc;
    int cl, cr;
  } vec_t;
  vec_t tv[6];
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic run_vec(input vec_t t, input int n);
    int va, vc;
    string p;
    p = $sformatf("vec%0d", n);
    ch_sample = t.s;
    ch_volume = t.v;
    ch_enable = t.e;
    master_mute = t.m;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    va = 0;
    vc = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (a_v) va |= 1 << k;
      if (c_v) vc |= 1 << k;
      if (k == 2) begin
        chk({p, " c_left"}, c_l, t.cl);
        chk({p, " c_right"}, c_r, t.cr);
        chk({p, " c_clip"}, c_c, 0);
      end
      if (k == 5) begin
        chk({p, " a_left"}, a_l, t.al);
        chk({p, " a_right"}, a_r, t.ar);
        chk({p, " a_clip"}, a_c, t.ac);
        chk({p, " b_left"}, b_l, t.bl);
        chk({p, " b_right"}, b_r, t.br);
        chk({p, " b_clip"}, b_c, t.bc);
        chk({p, " a_busy_last"}, a_b, 1);
      end
    end
    chk({p, " a_valid_mask"}, va, 1 << 5);
    chk({p, " c_valid_mask"}, vc, 1 << 2);
    chk({p, " a_busy_after"}, a_b, 0);
  endtask
  initial begin
    int cnt, vm, om;
    tv[0] = '{32'h0505057F, 16'h000F, 8'hFF, 1'b0, 476, 476, 0, 1905, 1905, 0, 476, 476};
    tv[1] = '{32'h80808080, 16'hFFFF, 8'hAA, 1'b0, -1920, 0, 0, -2048, 0, 2, -480, 0};
    tv[2] = '{32'h7F7F7F7F, 16'hFFFF, 8'hFF, 1'b0, 1905, 1905, 0, 2047, 2047, 3, 476, 476};
    tv[3] = '{32'h7F7F7F7F, 16'hFFFF, 8'hFF, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[4] = '{32'h80808080, 16'hFFFF, 8'hFF, 1'b0, -1920, -1920, 0, -2048, -2048, 3, -480, -480};
    tv[5] = '{32'h40FFCE64, 16'h1F73, 8'hB6, 1'b0, 87, -92, 0, 349, -365, 0, 75, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst left", a_l, 0);
    chk("rst right", a_r, 0);
    chk("rst valid", a_v, 0);
    chk("rst busy", a_b, 0);
    chk("rst clip", a_c, 0);
    chk("rst overrun", a_o, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) run_vec(tv[i], i);
    // abort a frame in ACCUM: outputs drop to zero and the frame never completes
    ch_sample = tv[2].s;
    ch_volume = tv[2].v;
    ch_enable = tv[2].e;
    master_mute = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("midrst busy", a_b, 0);
    chk("midrst left", a_l, 0);
    chk("midrst right", a_r, 0);
    chk("midrst valid", a_v, 0);
    chk("midrst b_left", b_l, 0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      cnt += int'(a_v) + int'(b_v);
    end
    chk("midrst no_valid", cnt, 0);
    // frame_start during reset is dropped
    reset = 1'b1;
    frame_start = 1'b1;
    tick();
    reset = 1'b0;
    frame_start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      cnt += int'(a_v) + int'(a_b);
    end
    chk("rst_start ignored", cnt, 0);
    // overrun: second request at T+2 and input change at T+1 must not disturb the frame
    ch_sample = tv[0].s;
    ch_volume = tv[0].v;
    ch_enable = tv[0].e;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    ch_sample = 32'h7F7F7F7F;
    ch_volume = 16'hFFFF;
    vm = 0;
    om = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      frame_start = (k == 1);
      if (a_v) vm |= 1 << k;
      if (a_o) om |= 1 << k;
      if (k == 5) begin
        chk("ovr left", a_l, 476);
        chk("ovr right", a_r, 476);
        chk("ovr clip", a_c, 0);
      end
    end
    frame_start = 1'b0;
    chk("ovr overrun_mask", om, 1 << 2);
    chk("ovr valid_mask", vm, 1 << 5);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
